// File: rtl/mem_io_pkg.sv
// Shared decode constants for mem_io_responder: IO select bit, IO window offsets, STATUS bit layout.
package mem_io_pkg;

   localparam int unsigned IO_SEL_BIT = 17;

   localparam logic [3:0] OFF_DATA   = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_CNT    = 4'h8;

   localparam int unsigned ST_TX_FULL  = 0;
   localparam int unsigned ST_RX_FULL  = 1;
   localparam int unsigned ST_TX_EMPTY = 2;

   function automatic logic [7:0] status_byte(input logic tx_full, input logic rx_full,
                                              input logic tx_empty);
      logic [7:0] s;
      s              = 8'h00;
      s[ST_TX_FULL]  = tx_full;
      s[ST_RX_FULL]  = rx_full;
      s[ST_TX_EMPTY] = tx_empty;
      return s;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO; wrap-bit pointers give full/empty, head is read straight from storage.
module byte_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] head_c,
   output logic       full_c,
   output logic       empty_c
);

   localparam int unsigned PW    = DEPTH_LOG2 + 1;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [PW-1:0] MSB_ONLY = PW'(1) << DEPTH_LOG2;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]    mem_q [DEPTH];
   logic          do_push_c, do_pop_c;

   always_comb begin
      full_c    = (wr_ptr_q ^ rd_ptr_q) == MSB_ONLY;
      empty_c   = wr_ptr_q == rd_ptr_q;
      do_push_c = push && !full_c;
      do_pop_c  = pop && !empty_c;
      wr_ptr_d  = wr_ptr_q + PW'(do_push_c);
      rd_ptr_d  = rd_ptr_q + PW'(do_pop_c);
      head_c    = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage holds no reset; only the pointers define contents.
   always_ff @(posedge clk) begin
      if (do_push_c) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
   end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-bus target: RAM plus IO window (TX FIFO, RX register, STATUS).
// Optional cycle counter at IO offsets 0x8-0xB when MEM_IO_CYCLE_COUNTER_EN is defined.
module mem_io_responder
   import mem_io_pkg::*;
#(
   parameter int unsigned RAM_ADDR_WIDTH = 17,
   parameter int unsigned TX_DEPTH_LOG2  = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        cpu_rdy,
   output logic [7:0]  io_tx_data,
   output logic        io_tx_valid,
   input  logic        io_tx_ready,
   input  logic [7:0]  io_rx_data,
   input  logic        io_rx_valid,
   output logic        io_rx_ready
);

   localparam int unsigned RAM_BYTES = 1 << RAM_ADDR_WIDTH;

   logic [7:0] ram_q [RAM_BYTES];
   logic [7:0] mem_din_q, mem_din_d;
   logic       rx_full_q, rx_full_d;
   logic [7:0] rx_data_q, rx_data_d;

   logic       is_io_c, io_data_c, io_data_wr_c, io_data_rd_c, ram_we_c;
   logic [3:0] off_c;
   logic       tx_full_c, tx_empty_c, tx_pop_c;
   logic [7:0] rdata_c;
   logic       unused_c;

   always_comb begin
      is_io_c      = mem_a[IO_SEL_BIT];
      off_c        = mem_a[3:0];
      io_data_c    = is_io_c && (off_c == OFF_DATA);
      cpu_rdy      = !(io_data_c && mem_wr && tx_full_c);
      io_data_wr_c = io_data_c && mem_wr && cpu_rdy;
      io_data_rd_c = io_data_c && !mem_wr;
      ram_we_c     = !is_io_c && mem_wr && cpu_rdy;
      tx_pop_c     = io_tx_valid && io_tx_ready;
   end

   byte_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
      .clk     (clk_in),
      .rst     (rst_in),
      .push    (io_data_wr_c),
      .pop     (tx_pop_c),
      .din     (mem_dout),
      .head_c  (io_tx_data),
      .full_c  (tx_full_c),
      .empty_c (tx_empty_c)
   );

   assign io_tx_valid = !tx_empty_c;
   assign io_rx_ready = !rx_full_q;
   assign mem_din     = mem_din_q;

`ifdef MEM_IO_CYCLE_COUNTER_EN
   logic [31:0] cnt_q, cnt_d, snap_q, snap_d;

   // Reading the low byte latches the whole count so the upper bytes stay coherent.
   always_comb begin
      cnt_d  = cnt_q + 32'd1;
      snap_d = snap_q;
      if (is_io_c && !mem_wr && (off_c == OFF_CNT)) snap_d = cnt_q;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt_q  <= '0;
         snap_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         snap_q <= snap_d;
      end
   end

   assign unused_c = ^{mem_a[31:IO_SEL_BIT+1], snap_q[7:0]};
`else
   assign unused_c = ^mem_a[31:IO_SEL_BIT+1];
`endif

   // Read mux; RAM path sees the pre-write contents on a write cycle.
   always_comb begin
      rdata_c = 8'h00;
      if (!is_io_c) begin
         rdata_c = ram_q[mem_a[RAM_ADDR_WIDTH-1:0]];
      end else if (off_c == OFF_DATA) begin
         rdata_c = rx_full_q ? rx_data_q : 8'h00;
      end else if (off_c == OFF_STATUS) begin
         rdata_c = status_byte(tx_full_c, rx_full_q, tx_empty_c);
`ifdef MEM_IO_CYCLE_COUNTER_EN
      end else if (off_c[3:2] == OFF_CNT[3:2]) begin
         case (off_c[1:0])
            2'd0:    rdata_c = cnt_q[7:0];
            2'd1:    rdata_c = snap_q[15:8];
            2'd2:    rdata_c = snap_q[23:16];
            default: rdata_c = snap_q[31:24];
         endcase
`endif
      end
   end

   always_comb begin
      mem_din_d = rdata_c;
      rx_full_d = rx_full_q;
      rx_data_d = rx_data_q;
      if (io_rx_valid && !rx_full_q) begin
         rx_full_d = 1'b1;
         rx_data_d = io_rx_data;
      end else if (io_data_rd_c) begin
         rx_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mem_din_q <= '0;
         rx_full_q <= 1'b0;
         rx_data_q <= '0;
      end else begin
         mem_din_q <= mem_din_d;
         rx_full_q <= rx_full_d;
         rx_data_q <= rx_data_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (ram_we_c) ram_q[mem_a[RAM_ADDR_WIDTH-1:0]] <= mem_dout;
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: read scoreboard plus TX FIFO reference queue.
module tb_mem_io_responder;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        cpu_rdy;
   logic [7:0]  io_tx_data;
   logic        io_tx_valid;
   logic        io_tx_ready;
   logic [7:0]  io_rx_data;
   logic        io_rx_valid;
   logic        io_rx_ready;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [7:0]  exp_q [$];
   logic [7:0]  tx_model [$];
   logic [31:0] tb_cnt;
   logic [7:0]  dmy;

   mem_io_responder dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .mem_a       (mem_a),
      .mem_wr      (mem_wr),
      .mem_dout    (mem_dout),
      .mem_din     (mem_din),
      .cpu_rdy     (cpu_rdy),
      .io_tx_data  (io_tx_data),
      .io_tx_valid (io_tx_valid),
      .io_tx_ready (io_tx_ready),
      .io_rx_data  (io_rx_data),
      .io_rx_valid (io_rx_valid),
      .io_rx_ready (io_rx_ready)
   );

   always #5 clk_in = ~clk_in;

   // Reference cycle count: cleared by reset, advances on every rising edge.
   always @(posedge clk_in or posedge rst_in) begin
      if (rst_in) tb_cnt <= 32'd0;
      else        tb_cnt <= tb_cnt + 32'd1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic bus_idle();
      mem_a    = 32'h0;
      mem_wr   = 1'b0;
      mem_dout = 8'h00;
   endtask

   task automatic wr(input logic [31:0] a, input logic [7:0] d);
      mem_a    = a;
      mem_wr   = 1'b1;
      mem_dout = d;
      tick();
      bus_idle();
   endtask

   task automatic tx_push(input logic [7:0] d);
      wr(32'h0003_0000, d);
      tx_model.push_back(d);
   endtask

   task automatic rd(input logic [31:0] a, input logic [7:0] exp, input string tag,
                     output logic [7:0] got);
      mem_a  = a;
      mem_wr = 1'b0;
      exp_q.push_back(exp);
      tick();
      got = mem_din;
      check_eq(tag, 32'(got), 32'(exp_q.pop_front()));
      bus_idle();
   endtask

   task automatic drain(input int n_exp, input string tag);
      int          n;
      logic [7:0]  e;
      n = 0;
      io_tx_ready = 1'b1;
      for (int k = 0; k < 64 && io_tx_valid; k++) begin
         e = (tx_model.size() > 0) ? tx_model.pop_front() : 8'hEE;
         check_eq(tag, 32'(io_tx_data), 32'(e));
         n++;
         tick();
      end
      io_tx_ready = 1'b0;
      check_eq({tag, "_count"}, 32'(n), 32'(n_exp));
      check_eq({tag, "_empty"}, 32'(io_tx_valid), 32'd0);
   endtask

   logic [16:0] r_addr [8];
   logic [7:0]  r_data [8];

   initial begin
      rst_in      = 1'b1;
      bus_idle();
      io_tx_ready = 1'b0;
      io_rx_valid = 1'b0;
      io_rx_data  = 8'h00;
      repeat (2) @(posedge clk_in);
      #1;
      check_eq("rst_mem_din", 32'(mem_din), 32'h00);
      check_eq("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
      check_eq("rst_tx_valid", 32'(io_tx_valid), 32'd0);
      check_eq("rst_rx_ready", 32'(io_rx_ready), 32'd1);
      rst_in = 1'b0;
      tick();

      // RAM: one-cycle read latency, old data on read-during-write, upper bits ignored
      wr(32'h0000_0010, 8'hA5);
      wr(32'h0000_0011, 8'h3C);
      rd(32'h0000_0011, 8'h3C, "ram_rd_11", dmy);
      mem_a = 32'h0000_0010;
      #1;
      check_eq("ram_prior_hold", 32'(mem_din), 32'h3C);
      rd(32'h0000_0010, 8'hA5, "ram_rd_10", dmy);
      mem_a    = 32'h0000_0010;
      mem_wr   = 1'b1;
      mem_dout = 8'h77;
      tick();
      check_eq("ram_rdw_old", 32'(mem_din), 32'hA5);
      bus_idle();
      rd(32'h0000_0010, 8'h77, "ram_rdw_new", dmy);
      wr(32'hFFFC_0020, 8'h5E);
      rd(32'h0000_0020, 8'h5E, "ram_hi_bits", dmy);
      for (int i = 0; i < 8; i++) begin
         r_addr[i] = (i == 7) ? 17'h1FFFF : 17'(i * 32'h3A17 + 32'h400);
         r_data[i] = 8'($urandom);
         wr({15'd0, r_addr[i]}, r_data[i]);
      end
      for (int i = 0; i < 8; i++) rd({15'd0, r_addr[i]}, r_data[i], "ram_rand", dmy);

      // IO window defaults
      rd(32'h0003_0004, 8'h04, "status_idle", dmy);
      rd(32'h0003_0001, 8'h00, "io_off1", dmy);
      rd(32'h0003_000C, 8'h00, "io_offC", dmy);
      rd(32'h0003_FFF4, 8'h04, "io_alias_status", dmy);
      wr(32'h0003_0004, 8'hFF);
      rd(32'h0003_0004, 8'h04, "status_ro", dmy);
`ifndef MEM_IO_CYCLE_COUNTER_EN
      for (int i = 8; i < 12; i++) rd(32'h0003_0000 + 32'(i), 8'h00, "cnt_absent", dmy);
`endif

      // TX fill to full, 17th write stalls until one pop
      check_eq("tx_valid_pre", 32'(io_tx_valid), 32'd0);
      for (int i = 0; i < 16; i++) begin
         mem_a    = 32'h0003_0000;
         mem_wr   = 1'b1;
         mem_dout = 8'(i);
         #1;
         if (i == 15) check_eq("rdy_16th", 32'(cpu_rdy), 32'd1);
         tick();
         tx_model.push_back(8'(i));
         if (i == 0) begin
            check_eq("tx_valid_post", 32'(io_tx_valid), 32'd1);
            check_eq("tx_head_first", 32'(io_tx_data), 32'h00);
         end
         bus_idle();
      end
      rd(32'h0003_0004, 8'h01, "status_full", dmy);
      mem_a    = 32'h0003_0000;
      mem_wr   = 1'b1;
      mem_dout = 8'h10;
      #1;
      check_eq("stall", 32'(cpu_rdy), 32'd0);
      tick();
      check_eq("stall_hold", 32'(cpu_rdy), 32'd0);
      check_eq("stall_head", 32'(io_tx_data), 32'h00);
      io_tx_ready = 1'b1;
      #1;
      check_eq("stall_pop_same", 32'(cpu_rdy), 32'd0);
      tick();
      io_tx_ready = 1'b0;
      void'(tx_model.pop_front());
      #1;
      check_eq("stall_release", 32'(cpu_rdy), 32'd1);
      check_eq("head_after_pop", 32'(io_tx_data), 32'h01);
      tick();
      tx_model.push_back(8'h10);
      bus_idle();
      rd(32'h0003_0004, 8'h01, "status_full_again", dmy);
      drain(16, "drain_full");
      rd(32'h0003_0004, 8'h04, "status_drained", dmy);

      // Simultaneous push and pop with three entries
      tx_push(8'hB0);
      tx_push(8'hB1);
      tx_push(8'hB2);
      mem_a       = 32'h0003_0000;
      mem_wr      = 1'b1;
      mem_dout    = 8'hB3;
      io_tx_ready = 1'b1;
      tick();
      io_tx_ready = 1'b0;
      void'(tx_model.pop_front());
      tx_model.push_back(8'hB3);
      bus_idle();
      check_eq("head_adv", 32'(io_tx_data), 32'hB1);
      rd(32'h0003_0004, 8'h00, "status_mid", dmy);
      drain(3, "drain_pp");

      mem_a    = 32'h0003_0000;
      mem_wr   = 1'b1;
      mem_dout = 8'hB8;
      #1;
      check_eq("empty_pre", 32'(io_tx_valid), 32'd0);
      tick();
      tx_model.push_back(8'hB8);
      bus_idle();
      check_eq("empty_post", 32'(io_tx_valid), 32'd1);
      drain(1, "drain_one");

      // RX register
      io_rx_data  = 8'h5C;
      io_rx_valid = 1'b1;
      #1;
      check_eq("rx_ready_pre", 32'(io_rx_ready), 32'd1);
      tick();
      io_rx_valid = 1'b0;
      check_eq("rx_ready_full", 32'(io_rx_ready), 32'd0);
      io_rx_data  = 8'h99;
      io_rx_valid = 1'b1;
      tick();
      io_rx_valid = 1'b0;
      rd(32'h0003_0004, 8'h06, "status_rx_full", dmy);
      rd(32'h0003_0000, 8'h5C, "rx_rd", dmy);
      check_eq("rx_ready_cleared", 32'(io_rx_ready), 32'd1);
      rd(32'h0003_0000, 8'h00, "rx_rd_empty", dmy);
      io_rx_data  = 8'h42;
      io_rx_valid = 1'b1;
      rd(32'h0003_0000, 8'h00, "rx_rd_with_load", dmy);
      io_rx_valid = 1'b0;
      rd(32'h0003_0000, 8'h42, "rx_rd_loaded", dmy);

`ifdef MEM_IO_CYCLE_COUNTER_EN
      begin
         logic [31:0] snap;
         logic [7:0]  g0, g1, g2, g3;
         logic [31:0] s1, s2;
         for (int k = 0; k < 300 && tb_cnt[7:0] != 8'hFF; k++) tick();
         check_eq("cnt_align", 32'(tb_cnt[7:0]), 32'hFF);
         snap = tb_cnt;
         rd(32'h0003_0008, snap[7:0], "cnt_b0", g0);
         rd(32'h0003_0009, snap[15:8], "cnt_b1", g1);
         rd(32'h0003_000A, snap[23:16], "cnt_b2", g2);
         rd(32'h0003_000B, snap[31:24], "cnt_b3", g3);
         s1 = {g3, g2, g1, g0};
         repeat (37) tick();
         snap = tb_cnt;
         rd(32'h0003_0008, snap[7:0], "cnt2_b0", g0);
         rd(32'h0003_0009, snap[15:8], "cnt2_b1", g1);
         rd(32'h0003_000A, snap[23:16], "cnt2_b2", g2);
         rd(32'h0003_000B, snap[31:24], "cnt2_b3", g3);
         s2 = {g3, g2, g1, g0};
         check_eq("cnt_delta", s2 - s1, 32'd41);
      end
`endif

      // Asynchronous reset in the middle of a stalled write
      for (int i = 0; i < 16; i++) tx_push(8'(8'h60 + i));
      io_rx_data  = 8'h33;
      io_rx_valid = 1'b1;
      tick();
      io_rx_valid = 1'b0;
      rd(32'h0000_0010, 8'h77, "pre_rst_rd", dmy);
      mem_a    = 32'h0003_0000;
      mem_wr   = 1'b1;
      mem_dout = 8'hEE;
      #1;
      check_eq("pre_rst_stall", 32'(cpu_rdy), 32'd0);
      check_eq("pre_rst_din", 32'(mem_din), 32'h77);
      #2;
      rst_in = 1'b1;
      #1;
      check_eq("arst_cpu_rdy", 32'(cpu_rdy), 32'd1);
      check_eq("arst_tx_valid", 32'(io_tx_valid), 32'd0);
      check_eq("arst_mem_din", 32'(mem_din), 32'h00);
      check_eq("arst_rx_ready", 32'(io_rx_ready), 32'd1);
      bus_idle();
      tx_model.delete();
      tick();
      rst_in = 1'b0;
      tick();
      rd(32'h0000_0010, 8'h77, "ram_survives_rst", dmy);
      rd(32'h0003_0004, 8'h04, "status_after_rst", dmy);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Target-side responder for the CPU's byte-wide memory bus (mem_a / mem_wr / mem_dout / mem_din); sits opposite the CPU's memory controller.
- Serves a byte RAM plus a small memory-mapped IO window.
- IO window: buffered transmit FIFO, single-entry receive register, status register.
- Back-pressures the CPU through cpu_rdy when a transmit write cannot be accepted.

Parameters:
RAM_ADDR_WIDTH, 17, byte-address width of internal RAM (2^17 bytes)
TX_DEPTH_LOG2, 4, log2 of transmit FIFO depth (16 entries)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-high reset
mem_a  input  32  byte address from CPU
mem_wr  input  1  1 = write, 0 = read
mem_dout  input  8  write data from CPU
mem_din  output  8  read data to CPU
cpu_rdy  output  1  drives CPU rdy_in; low = stall
io_tx_data  output  8  FIFO head byte
io_tx_valid  output  1  FIFO non-empty
io_tx_ready  input  1  sink accepts head this cycle
io_rx_data  input  8  incoming byte
io_rx_valid  input  1  incoming byte present
io_rx_ready  output  1  receive register empty

Behaviour:
- Decode: mem_a[17]=0 selects RAM, indexed by mem_a[RAM_ADDR_WIDTH-1:0]. mem_a[17]=1 selects IO; mem_a[3:0] is the offset; other bits are ignored.
- IO offsets:
  - 0x0 = DATA. Write pushes to TX; read pops RX.
  - 0x4 = STATUS, read-only. bit0 tx_full, bit1 rx_full, bit2 tx_empty.
  - Other offsets read 0x00; writes to them are ignored.
- Read latency: exactly 1 cycle. mem_din is registered; the address presented at edge N gives data valid after edge N.
- Writes commit at the rising edge where mem_wr=1 and cpu_rdy=1.
- RAM is synchronous single-port with no reset. Read-during-write returns old data.
- TX FIFO:
  - Pointers carry an extra wrap bit. full when pointers differ only in the MSB; empty when equal.
  - Push on an IO DATA write. Pop when io_tx_valid && io_tx_ready.
  - No bypass: a byte pushed into an empty FIFO appears on io_tx_data the next cycle.
  - Push and pop in the same cycle when not full/empty: count unchanged.
- Stall: cpu_rdy = !(IO DATA write && tx_full), combinational from the registered full flag.
  - A pop in the same cycle does not release the stall.
  - The CPU holds the bus while stalled, so the write retries next cycle.
- RX register:
  - Loads io_rx_data when io_rx_valid && !rx_full. io_rx_ready = !rx_full.
  - An IO DATA read returns the register value when rx_full, else 0x00; it clears rx_full.
  - Clear and load in the same cycle cannot occur, because io_rx_ready is low when full.
- Reset (async, rst_in=1):
  - mem_din=0x00, pointers=0, rx_full=0. So io_tx_valid=0, io_rx_ready=1, cpu_rdy=1.
  - RAM contents are preserved. Reset mid-stall drops the pending write.
- Wrap-around: pointers wrap modulo 2^(TX_DEPTH_LOG2+1); 16 pushes from empty gives full; the 17th push stalls.

Optional Feature:
- Macro MEM_IO_CYCLE_COUNTER_EN.
- Defined:
  - 32-bit free-running cycle counter, reset to 0, increments every clk_in.
  - Readable little-endian at IO offsets 0x8–0xB.
  - The full 32-bit value is snapshotted when offset 0x8 is read; offsets 0x9–0xB return snapshot bytes.
- Undefined: offsets 0x8–0xB read 0x00 and no counter logic exists.

Decomposition:
- Package mem_io_pkg: IO select bit index (17), offsets DATA=0x0, STATUS=0x4, CNT=0x8, STATUS bit indices.
- Sub-module byte_fifo: parameterised synchronous FIFO with push/pop/full/empty/head outputs, used for TX.

Test Plan:
- RAM write 0xA5 to 0x00010, then read 0x00010 → mem_din=0xA5 one cycle after the read address; the prior cycle's value is unchanged.
- Push bytes 0x00..0x0F to 0x30000 with io_tx_ready=0 → STATUS=0x01. The 17th write drops cpu_rdy until io_tx_ready=1 for one cycle, then commits; io_tx_data=0x00 first.
- io_rx_valid=1, io_rx_data=0x5C → io_rx_ready falls next cycle. Read 0x30000 → 0x5C, rx_full clears. A second read → 0x00.
- Push and pop in the same cycle with 3 entries → count stays 3, head advances. Push into empty → io_tx_valid rises one cycle later.
- Assert rst_in asynchronously mid-stall → cpu_rdy=1, io_tx_valid=0, mem_din=0x00 immediately; RAM data written earlier still reads back.
- MEM_IO_CYCLE_COUNTER_EN defined: read 0x30008..0x3000B → bytes of a single snapshot. Two snapshots N cycles apart differ by N.
